core_mem_arbiter: RTL

- Shares one single-port synchronous RAM between the RISC-V core's instruction-fetch port and its load/store port.
- Round-robin arbitration: at most one access is issued to memory per cycle.
- Read data is routed back to the owning requester after the fixed memory read latency.
- Sits between the core (iaddr/idata, ddata_r/ddata_w/d_rw signals) and the unified memory model in the Fase3 system.

---
 rtl/core_mem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Brief    : Round-robin arbiter sharing one single-port synchronous RAM
//            between the instruction-fetch and load/store ports of the core.
// Revision : 1.0  initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [0:0] c_INSTR = 1'b0;
    localparam logic [0:0] c_DATA  = 1'b1;

    logic [0:0]         r_last_gnt;
    logic [MEM_LAT-1:0] r_tag_valid;
    logic [MEM_LAT-1:0] r_tag_owner;

    logic w_i_gnt;
    logic w_d_gnt;
    logic w_issue_rd;
    logic w_issue_owner;
    logic w_ret_valid;
    logic w_ret_owner;

    // Under contention the requester that did not win last time gets the slot.
    assign w_i_gnt = ~RESET & i_req & (~d_req | (r_last_gnt == c_DATA));
    assign w_d_gnt = ~RESET & d_req & (~i_req | (r_last_gnt == c_INSTR));

    assign w_issue_rd    = w_i_gnt | (w_d_gnt & ~d_we);
    assign w_issue_owner = w_d_gnt ? c_DATA : c_INSTR;

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (w_i_gnt) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
            mem_be   = '1;
        end else if (w_d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last_gnt  <= c_INSTR;
            r_tag_valid <= '0;
            r_tag_owner <= '0;
        end else begin
            if (w_i_gnt) begin
                r_last_gnt <= c_INSTR;
            end else if (w_d_gnt) begin
                r_last_gnt <= c_DATA;
            end
            r_tag_valid[0] <= w_issue_rd;
            r_tag_owner[0] <= w_issue_owner;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_tag_valid[k] <= r_tag_valid[k-1];
                r_tag_owner[k] <= r_tag_owner[k-1];
            end
        end
    end

    // The tail of the tag pipe lines up with the cycle mem_rdata is valid.
    assign w_ret_valid = r_tag_valid[MEM_LAT-1] & ~RESET;
    assign w_ret_owner = r_tag_owner[MEM_LAT-1];

    assign i_rvalid = w_ret_valid & (w_ret_owner == c_INSTR);
    assign d_rvalid = w_ret_valid & (w_ret_owner == c_DATA);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire
